// File: rtl/sha_sigma_pipe_if.sv
// rtl/sha_sigma_pipe_if.sv - operand/result handshake bundle for the sigma pipe
interface sha_sigma_pipe_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_mode;
    logic [WIDTH-1:0] in_word;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_word;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_mode, in_word, in_tag, out_ready,
        input  in_ready, out_valid, out_word, out_tag
    );

    modport slave (
        input  in_valid, in_mode, in_word, in_tag, out_ready,
        output in_ready, out_valid, out_word, out_tag
    );
endinterface

// File: rtl/sha_sigma_pipe.sv
// rtl/sha_sigma_pipe.sv - two-stage elastic SHA-2 Sigma0/Sigma1/sigma0/sigma1 unit
module sha_sigma_pipe #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input logic           clk,
    input logic           rst,
    sha_sigma_pipe_if.slave bus
);
    localparam bit W64 = (WIDTH == 64);

    localparam int BS0_A = W64 ? 28 : 2;
    localparam int BS0_B = W64 ? 34 : 13;
    localparam int BS0_C = W64 ? 39 : 22;
    localparam int BS1_A = W64 ? 14 : 6;
    localparam int BS1_B = W64 ? 18 : 11;
    localparam int BS1_C = W64 ? 41 : 25;
    localparam int SS0_A = W64 ? 1  : 7;
    localparam int SS0_B = W64 ? 8  : 18;
    localparam int SS0_C = W64 ? 7  : 3;
    localparam int SS1_A = W64 ? 19 : 17;
    localparam int SS1_B = W64 ? 61 : 19;
    localparam int SS1_C = W64 ? 6  : 10;

    function automatic logic [WIDTH-1:0] rotr(input logic [WIDTH-1:0] x, input int n);
        return (x >> n) | (x << (WIDTH - n));
    endfunction

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a, s1_b, s1_c;
    logic [TAG_W-1:0] s1_tag;
    logic             s2_move, s1_move;
    logic [WIDTH-1:0] t_a, t_b, t_c;

    assign s2_move     = !bus.out_valid || bus.out_ready;
    assign s1_move     = !s1_valid || s2_move;
    assign bus.in_ready = s1_move;

    // Lower-case sigmas use a logical shift for their third term, not a rotate.
    always_comb begin
        t_a = '0;
        t_b = '0;
        t_c = '0;
        case (bus.in_mode)
            2'd0: begin
                t_a = rotr(bus.in_word, BS0_A);
                t_b = rotr(bus.in_word, BS0_B);
                t_c = rotr(bus.in_word, BS0_C);
            end
            2'd1: begin
                t_a = rotr(bus.in_word, BS1_A);
                t_b = rotr(bus.in_word, BS1_B);
                t_c = rotr(bus.in_word, BS1_C);
            end
            2'd2: begin
                t_a = rotr(bus.in_word, SS0_A);
                t_b = rotr(bus.in_word, SS0_B);
                t_c = bus.in_word >> SS0_C;
            end
            default: begin
                t_a = rotr(bus.in_word, SS1_A);
                t_b = rotr(bus.in_word, SS1_B);
                t_c = bus.in_word >> SS1_C;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_word  <= '0;
            bus.out_tag   <= '0;
        end else begin
            if (s1_move)
                s1_valid <= bus.in_valid;
            if (s2_move) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_word <= s1_a ^ s1_b ^ s1_c;
                    bus.out_tag  <= s1_tag;
                end
            end
        end
    end

    // Stage-1 payload carries no reset; s1_valid alone qualifies it.
    always_ff @(posedge clk) begin
        if (s1_move && bus.in_valid) begin
            s1_a   <= t_a;
            s1_b   <= t_b;
            s1_c   <= t_c;
            s1_tag <= bus.in_tag;
        end
    end
endmodule

// File: tb/tb_sha_sigma_pipe.sv
// tb/tb_sha_sigma_pipe.sv - scoreboard bench for sha_sigma_pipe at WIDTH 32 and 64
module tb_sha_sigma_pipe;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sha_sigma_pipe_if #(.WIDTH(32), .TAG_W(4)) bus32 ();
    sha_sigma_pipe_if #(.WIDTH(64), .TAG_W(4)) bus64 ();

    sha_sigma_pipe #(.WIDTH(32), .TAG_W(4)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    sha_sigma_pipe #(.WIDTH(64), .TAG_W(4)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    typedef struct {
        logic [63:0] w;
        logic [3:0]  t;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    bit   rand_rdy = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] rot(input logic [63:0] x, input int n, input int w);
        logic [63:0] m;
        m = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        return ((x >> n) | (x << (w - n))) & m;
    endfunction

    // Reference: the SHA-2 sigma definitions written out as rotation/shift tables.
    function automatic logic [63:0] ref_sigma(input int w, input int mode, input logic [63:0] x);
        int a, b, c;
        logic [63:0] m, xm, third;
        m  = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        xm = x & m;
        if (w == 64) begin
            case (mode)
                0: begin a = 28; b = 34; c = 39; end
                1: begin a = 14; b = 18; c = 41; end
                2: begin a = 1;  b = 8;  c = 7;  end
                default: begin a = 19; b = 61; c = 6; end
            endcase
        end else begin
            case (mode)
                0: begin a = 2;  b = 13; c = 22; end
                1: begin a = 6;  b = 11; c = 25; end
                2: begin a = 7;  b = 18; c = 3;  end
                default: begin a = 17; b = 19; c = 10; end
            endcase
        end
        third = (mode >= 2) ? (xm >> c) : rot(xm, c, w);
        return (rot(xm, a, w) ^ rot(xm, b, w) ^ third) & m;
    endfunction

    // Called at a negedge; returns at the negedge following acceptance.
    task automatic send32(input logic [1:0] m, input logic [31:0] x, input logic [3:0] t);
        bit done = 1'b0;
        int budget = 0;
        exp_t e;
        bus32.in_valid = 1'b1;
        bus32.in_mode  = m;
        bus32.in_word  = x;
        bus32.in_tag   = t;
        while (!done) begin
            #1;
            if (bus32.in_ready) begin
                done = 1'b1;
                e.w = ref_sigma(32, int'(m), {32'h0, x});
                e.t = t;
                q32.push_back(e);
            end
            @(negedge clk);
            budget++;
            if (!done && budget > 200) begin
                chk("send32_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
        end
        bus32.in_valid = 1'b0;
    endtask

    task automatic send64(input logic [1:0] m, input logic [63:0] x, input logic [3:0] t);
        bit done = 1'b0;
        int budget = 0;
        exp_t e;
        bus64.in_valid = 1'b1;
        bus64.in_mode  = m;
        bus64.in_word  = x;
        bus64.in_tag   = t;
        while (!done) begin
            #1;
            if (bus64.in_ready) begin
                done = 1'b1;
                e.w = ref_sigma(64, int'(m), x);
                e.t = t;
                q64.push_back(e);
            end
            @(negedge clk);
            budget++;
            if (!done && budget > 200) begin
                chk("send64_timeout", 64'd0, 64'd1);
                done = 1'b1;
            end
        end
        bus64.in_valid = 1'b0;
    endtask

    // Pipe must be empty and out_ready high: result is visible one edge after the accept edge.
    task automatic direct32(input string name, input logic [1:0] m, input logic [31:0] x,
                            input logic [31:0] exp, input logic [3:0] t);
        send32(m, x, t);
        #1 chk({name, "_early"}, {63'd0, bus32.out_valid}, 64'd0);
        @(negedge clk);
        #1 chk({name, "_valid"}, {63'd0, bus32.out_valid}, 64'd1);
        chk({name, "_word"}, {32'h0, bus32.out_word}, {32'h0, exp});
        chk({name, "_tag"}, {60'd0, bus32.out_tag}, {60'd0, t});
    endtask

    task automatic direct64(input string name, input logic [1:0] m, input logic [63:0] x,
                            input logic [63:0] exp, input logic [3:0] t);
        send64(m, x, t);
        #1 chk({name, "_early"}, {63'd0, bus64.out_valid}, 64'd0);
        @(negedge clk);
        #1 chk({name, "_valid"}, {63'd0, bus64.out_valid}, 64'd1);
        chk({name, "_word"}, bus64.out_word, exp);
    endtask

    task automatic drain();
        int budget = 0;
        while ((q32.size() != 0 || q64.size() != 0) && budget < 300) begin
            @(negedge clk);
            budget++;
        end
        if (q32.size() != 0 || q64.size() != 0)
            chk("drain_timeout", 64'(q32.size() + q64.size()), 64'd0);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rand_rdy)
            bus32.out_ready = 1'($urandom_range(0, 1));
    end

    // Monitor 32: pops on each transfer, and holds stalled outputs to their previous values.
    logic        p_stall32 = 1'b0;
    logic [31:0] p_word32;
    logic [3:0]  p_tag32;
    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (rst) begin
            p_stall32 = 1'b0;
        end else begin
            if (p_stall32) begin
                chk("stall32_valid", {63'd0, bus32.out_valid}, 64'd1);
                chk("stall32_word", {32'h0, bus32.out_word}, {32'h0, p_word32});
                chk("stall32_tag", {60'd0, bus32.out_tag}, {60'd0, p_tag32});
            end
            if (bus32.out_valid && bus32.out_ready) begin
                if (q32.size() == 0) begin
                    chk("mon32_unexpected", 64'd1, 64'd0);
                end else begin
                    e = q32.pop_front();
                    chk("mon32_word", {32'h0, bus32.out_word}, e.w);
                    chk("mon32_tag", {60'd0, bus32.out_tag}, {60'd0, e.t});
                end
            end
            p_stall32 = bus32.out_valid && !bus32.out_ready;
            p_word32  = bus32.out_word;
            p_tag32   = bus32.out_tag;
        end
    end

    always begin
        exp_t e;
        @(negedge clk);
        #2;
        if (!rst && bus64.out_valid && bus64.out_ready) begin
            if (q64.size() == 0) begin
                chk("mon64_unexpected", 64'd1, 64'd0);
            end else begin
                e = q64.pop_front();
                chk("mon64_word", bus64.out_word, e.w);
                chk("mon64_tag", {60'd0, bus64.out_tag}, {60'd0, e.t});
            end
        end
    end

    initial begin
        bus32.in_valid = 1'b0; bus32.in_mode = 2'd0; bus32.in_word = '0; bus32.in_tag = '0;
        bus32.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.in_mode = 2'd0; bus64.in_word = '0; bus64.in_tag = '0;
        bus64.out_ready = 1'b1;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {63'd0, bus32.out_valid}, 64'd0);
        chk("rst_out_word", {32'h0, bus32.out_word}, 64'd0);
        chk("rst_out_tag", {60'd0, bus32.out_tag}, 64'd0);
        chk("rst_in_ready", {63'd0, bus32.in_ready}, 64'd1);
        chk("rst64_out_word", bus64.out_word, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        direct32("t1_S0", 2'd0, 32'h6a09e667, 32'hce20b47e, 4'd1);
        direct32("t2_S1", 2'd1, 32'h510e527f, 32'h3587272b, 4'd2);
        direct32("t2_s0", 2'd2, 32'h00000001, 32'h02004000, 4'd3);
        direct32("t2_s1", 2'd3, 32'h00000001, 32'h0000a000, 4'd4);
        direct64("t3_S0", 2'd0, 64'h1, 64'h0000001042000000, 4'd5);
        direct64("t3_s0", 2'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h01ffffffffffffff, 4'd6);
        drain();

        for (int i = 0; i < 12; i++)
            send64(2'($urandom_range(0, 3)), {$urandom, $urandom}, 4'(i));
        drain();

        rand_rdy = 1'b1;
        for (int i = 0; i < 16; i++)
            send32(2'($urandom_range(0, 3)), $urandom, 4'(i));
        for (int i = 0; i < 48; i++) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send32(2'($urandom_range(0, 3)), $urandom, 4'(i));
        end
        drain();
        rand_rdy = 1'b0;
        @(negedge clk);

        bus32.out_ready = 1'b0;
        send32(2'd1, 32'hdeadbeef, 4'd7);
        send32(2'd2, 32'h12345678, 4'd8);
        #1 chk("t5_full_in_ready", {63'd0, bus32.in_ready}, 64'd0);
        bus32.in_valid = 1'b1; bus32.in_mode = 2'd3; bus32.in_word = 32'hcafef00d; bus32.in_tag = 4'd9;
        @(negedge clk);
        #1 chk("t5_stall_in_ready", {63'd0, bus32.in_ready}, 64'd0);
        @(negedge clk);
        bus32.out_ready = 1'b1;
        #1 chk("t5_pop_in_ready", {63'd0, bus32.in_ready}, 64'd1);
        q32.push_back('{w: ref_sigma(32, 3, 64'hcafef00d), t: 4'd9});
        @(negedge clk);
        bus32.in_valid = 1'b0;
        #1 chk("t5_after_valid", {63'd0, bus32.out_valid}, 64'd1);
        chk("t5_after_tag", {60'd0, bus32.out_tag}, 64'd8);
        drain();

        bus32.out_ready = 1'b0;
        send32(2'd0, $urandom, 4'd10);
        send32(2'd3, $urandom, 4'd11);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", {63'd0, bus32.out_valid}, 64'd0);
        chk("t6_rst_word", {32'h0, bus32.out_word}, 64'd0);
        chk("t6_rst_in_ready", {63'd0, bus32.in_ready}, 64'd1);
        q32.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        bus32.out_ready = 1'b1;
        #1 chk("t6_post_valid", {63'd0, bus32.out_valid}, 64'd0);
        @(negedge clk);
        direct32("t6_new", 2'd0, 32'h6a09e667, 32'hce20b47e, 4'd12);
        drain();
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end
endmodule
